// File: rtl/knn_pkg.sv
// Shared definitions for the KNN sequencer: FSM state encoding and the
// point-memory address map (test points first, data points after them).
package knn_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_TEST = 3'd1,
    FETCH   = 3'd2,
    DIST    = 3'd3,
    INSERT  = 3'd4,
    VOTE    = 3'd5,
    WRITE   = 3'd6,
    DONE    = 3'd7
  } knn_state_e;

  localparam int TEST_BASE = 0;

  // Data points live directly after the M test points.
  function automatic int data_base(input int m);
    return m;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/knn_idx_cnt.sv
// Up-counter from 0 to MAX with synchronous clear and enable; holds at MAX
// so it only ever wraps through an explicit clear.
module knn_idx_cnt
  import knn_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MAX));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/knn_seq_ctrl.sv
// KNN accelerator sequencer: walks M test points x N data points through
// fetch, distance, neighbour insert, then label vote and result write.
module knn_seq_ctrl
  import knn_pkg::*;
#(
  parameter int M        = 4,
  parameter int N        = 10,
  parameter int DIST_LAT = 2,
  parameter int ADDR_W   = 4,
  localparam int RES_W   = cnt_w(M - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              ld_test,
  output logic              ld_data,
  output logic              nb_clr,
  output logic              dist_en,
  output logic              ins_req,
  input  logic              ins_done,
  output logic              vote_req,
  input  logic              vote_done,
  output logic              res_we,
  output logic [RES_W-1:0]  res_addr
);

  localparam int DATA_W_IDX = cnt_w(N - 1);
  localparam int LAT_W      = cnt_w(DIST_LAT - 1);

  knn_state_e state_q, state_d;
  logic       ld_test_q, ld_test_d;

  logic                  test_clr, test_en, test_tc;
  logic                  data_clr, data_en, data_tc;
  logic                  lat_clr, lat_en, lat_tc;
  logic [RES_W-1:0]      test_idx;
  logic [DATA_W_IDX-1:0] data_idx;
  logic [LAT_W-1:0]      lat_cnt;

  knn_idx_cnt #(.MAX(M - 1), .W(RES_W)) u_test_cnt (
    .clk_i (clk), .rst_ni(rst), .clr_i(test_clr), .en_i(test_en),
    .cnt_o (test_idx), .tc_o(test_tc)
  );

  knn_idx_cnt #(.MAX(N - 1), .W(DATA_W_IDX)) u_data_cnt (
    .clk_i (clk), .rst_ni(rst), .clr_i(data_clr), .en_i(data_en),
    .cnt_o (data_idx), .tc_o(data_tc)
  );

  knn_idx_cnt #(.MAX(DIST_LAT - 1), .W(LAT_W)) u_lat_cnt (
    .clk_i (clk), .rst_ni(rst), .clr_i(lat_clr), .en_i(lat_en),
    .cnt_o (lat_cnt), .tc_o(lat_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ld_test_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_test_q <= ld_test_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_test_d = 1'b0;
    test_clr  = 1'b0;
    test_en   = 1'b0;
    data_clr  = 1'b0;
    data_en   = 1'b0;
    lat_clr   = 1'b0;
    lat_en    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = LD_TEST;
      LD_TEST: if (mem_ack) begin
                 ld_test_d = 1'b1;
                 data_clr  = 1'b1;
                 state_d   = FETCH;
               end
      FETCH:   if (mem_ack) begin
                 lat_clr = 1'b1;
                 state_d = DIST;
               end
      DIST:    if (lat_tc) state_d = INSERT;
               else        lat_en  = 1'b1;
      INSERT:  if (ins_done) begin
                 if (data_tc) state_d = VOTE;
                 else begin
                   data_en = 1'b1;
                   state_d = FETCH;
                 end
               end
      VOTE:    if (vote_done) state_d = WRITE;
      WRITE:   if (test_tc) begin
                 test_clr = 1'b1;
                 state_d  = DONE;
               end else begin
                 test_en = 1'b1;
                 state_d = LD_TEST;
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ld_data marks the first DIST cycle since lat_cnt is cleared on entry.
  always_comb begin
    mem_addr = '0;
    case (state_q)
      LD_TEST: mem_addr = ADDR_W'(TEST_BASE) + ADDR_W'(test_idx);
      FETCH:   mem_addr = ADDR_W'(data_base(M)) + ADDR_W'(data_idx);
      default: mem_addr = '0;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mem_req  = (state_q == LD_TEST) || (state_q == FETCH);
  assign ld_test  = ld_test_q;
  assign nb_clr   = ld_test_q;
  assign ld_data  = (state_q == DIST) && (lat_cnt == '0);
  assign dist_en  = (state_q == DIST);
  assign ins_req  = (state_q == INSERT);
  assign vote_req = (state_q == VOTE);
  assign res_we   = (state_q == WRITE);
  assign res_addr = test_idx;

endmodule
